// File: rtl/ast_width_packer_pkg.sv
// rtl/ast_width_packer_pkg.sv - shared FSM state type and empty-count helper for the AST width packer
`timescale 1ns/1ps
package ast_width_packer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Empty bytes on the eop word: the unfilled slices plus the empty bytes of the eop beat.
  function automatic int calc_empty(input int ratio, input int bytes_in, input int slice,
                                    input int snk_empty);
    return (ratio - 1 - slice) * bytes_in + snk_empty;
  endfunction

endpackage

// File: rtl/ast_src_stage.sv
// rtl/ast_src_stage.sv - source output register of an AST stream with valid/ready hold logic
`timescale 1ns/1ps
module ast_src_stage #(
  parameter int DATA_W    = 128,
  parameter int EMPTY_W   = 4,
  parameter int CHANNEL_W = 8
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 load,
  input  logic [DATA_W-1:0]    data,
  input  logic                 sop,
  input  logic                 eop,
  input  logic [EMPTY_W-1:0]   empty,
  input  logic [CHANNEL_W-1:0] channel,
  input  logic                 src_ready,
  output logic                 src_valid,
  output logic [DATA_W-1:0]    src_data,
  output logic                 src_sop,
  output logic                 src_eop,
  output logic [EMPTY_W-1:0]   src_empty,
  output logic [CHANNEL_W-1:0] src_channel
);

  // load is only raised when the register is free or being drained this edge.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      src_valid   <= 1'b0;
      src_data    <= '0;
      src_sop     <= 1'b0;
      src_eop     <= 1'b0;
      src_empty   <= '0;
      src_channel <= '0;
    end else if (load) begin
      src_valid   <= 1'b1;
      src_data    <= data;
      src_sop     <= sop;
      src_eop     <= eop;
      src_empty   <= empty;
      src_channel <= channel;
    end else if (src_ready) begin
      src_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ast_width_packer.sv
// rtl/ast_width_packer.sv - packs RATIO narrow Avalon-ST beats into one wide word, carrying sop/eop/empty/channel
`timescale 1ns/1ps
module ast_width_packer
  import ast_width_packer_pkg::*;
#(
  parameter int  DATA_IN_W   = 32,
  parameter int  RATIO       = 4,
  parameter int  CHANNEL_W   = 8,
  localparam int BYTES_IN    = DATA_IN_W / 8,
  localparam int DATA_OUT_W  = DATA_IN_W * RATIO,
  localparam int EMPTY_IN_W  = $clog2(BYTES_IN),
  localparam int EMPTY_OUT_W = $clog2(DATA_OUT_W / 8)
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic [DATA_IN_W-1:0]   snk_data_i,
  input  logic                   snk_startofpacket_i,
  input  logic                   snk_endofpacket_i,
  input  logic                   snk_valid_i,
  input  logic [EMPTY_IN_W-1:0]  snk_empty_i,
  input  logic [CHANNEL_W-1:0]   snk_channel_i,
  output logic                   snk_ready_o,
  output logic [DATA_OUT_W-1:0]  src_data_o,
  output logic                   src_startofpacket_o,
  output logic                   src_endofpacket_o,
  output logic                   src_valid_o,
  output logic [EMPTY_OUT_W-1:0] src_empty_o,
  output logic [CHANNEL_W-1:0]   src_channel_o,
  input  logic                   src_ready_i,
  output logic                   err_o
);

  localparam int BCNT_W = $clog2(RATIO);

  state_t                 state;
  logic [BCNT_W-1:0]      beat_cnt;
  logic [DATA_OUT_W-1:0]  acc;
  logic                   acc_sop;
  logic [CHANNEL_W-1:0]   chan_q;
  logic                   run;
  logic                   err_q;

  logic                   accept, cont, pack, emit, err_next, word_sop;
  logic [BCNT_W-1:0]      slice;
  logic [DATA_OUT_W-1:0]  word;
  logic [EMPTY_OUT_W-1:0] word_empty;
  logic [CHANNEL_W-1:0]   word_chan;

  assign snk_ready_o = run & (!src_valid_o | src_ready_i);
  assign err_o       = err_q;

  // cont: beat extends the open packet; any sop beat restarts at slice 0 with a clean word.
  always_comb begin
    accept = snk_valid_i & snk_ready_o;
    cont   = (state == ACCUM) & !snk_startofpacket_i;
    pack   = accept & (cont | snk_startofpacket_i);
    slice  = cont ? beat_cnt : '0;
    word   = cont ? acc : '0;
    for (int i = 0; i < RATIO; i++) begin
      if (slice == BCNT_W'(i)) word[DATA_OUT_W-1-i*DATA_IN_W -: DATA_IN_W] = snk_data_i;
    end
    emit       = pack & (snk_endofpacket_i | (slice == BCNT_W'(RATIO - 1)));
    word_sop   = cont ? acc_sop : 1'b1;
    word_chan  = cont ? chan_q : snk_channel_i;
    word_empty = snk_endofpacket_i
               ? EMPTY_OUT_W'(calc_empty(RATIO, BYTES_IN, int'(slice), int'(snk_empty_i)))
               : '0;
    err_next   = accept & (((state == IDLE) & !snk_startofpacket_i)
                         | ((state == ACCUM) & snk_startofpacket_i)
                         | (cont & (snk_channel_i != chan_q)));
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
      acc      <= '0;
      acc_sop  <= 1'b0;
      chan_q   <= '0;
      run      <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      run   <= 1'b1;
      err_q <= err_next;
      if (pack) begin
        if (snk_startofpacket_i) chan_q <= snk_channel_i;
        if (emit) begin
          acc      <= '0;
          acc_sop  <= 1'b0;
          beat_cnt <= '0;
          state    <= snk_endofpacket_i ? IDLE : ACCUM;
        end else begin
          acc      <= word;
          acc_sop  <= word_sop;
          beat_cnt <= slice + 1'b1;
          state    <= ACCUM;
        end
      end
    end
  end

  ast_src_stage #(
    .DATA_W    (DATA_OUT_W),
    .EMPTY_W   (EMPTY_OUT_W),
    .CHANNEL_W (CHANNEL_W)
  ) u_src_stage (
    .clk         (clk),
    .arst_n      (arst_n),
    .load        (emit),
    .data        (word),
    .sop         (word_sop),
    .eop         (snk_endofpacket_i),
    .empty       (word_empty),
    .channel     (word_chan),
    .src_ready   (src_ready_i),
    .src_valid   (src_valid_o),
    .src_data    (src_data_o),
    .src_sop     (src_startofpacket_o),
    .src_eop     (src_endofpacket_o),
    .src_empty   (src_empty_o),
    .src_channel (src_channel_o)
  );

endmodule

// File: tb/tb_ast_width_packer.sv
// tb/tb_ast_width_packer.sv - self-checking bench for ast_width_packer (32-bit sink, ratio 4)
`timescale 1ns/1ps
module tb_ast_width_packer;

  typedef struct packed {
    logic [127:0] data;
    logic         sop;
    logic         eop;
    logic [3:0]   empty;
    logic [7:0]   ch;
  } out_t;

  logic         clk = 1'b0;
  logic         arst_n = 1'b1;
  logic [31:0]  snk_data_i = '0;
  logic         snk_startofpacket_i = 1'b0, snk_endofpacket_i = 1'b0, snk_valid_i = 1'b0;
  logic [1:0]   snk_empty_i = '0;
  logic [7:0]   snk_channel_i = '0;
  logic         snk_ready_o;
  logic [127:0] src_data_o;
  logic         src_startofpacket_o, src_endofpacket_o, src_valid_o;
  logic [3:0]   src_empty_o;
  logic [7:0]   src_channel_o;
  logic         src_ready_i = 1'b1;
  logic         err_o;

  int   tests = 0, fails = 0, err_seen = 0;
  bit   bp_en = 0;
  out_t got_q[$], exp_q[$];
  out_t mon_w;

  ast_width_packer #(.DATA_IN_W(32), .RATIO(4), .CHANNEL_W(8)) dut (
    .clk(clk), .arst_n(arst_n),
    .snk_data_i(snk_data_i), .snk_startofpacket_i(snk_startofpacket_i),
    .snk_endofpacket_i(snk_endofpacket_i), .snk_valid_i(snk_valid_i),
    .snk_empty_i(snk_empty_i), .snk_channel_i(snk_channel_i), .snk_ready_o(snk_ready_o),
    .src_data_o(src_data_o), .src_startofpacket_o(src_startofpacket_o),
    .src_endofpacket_o(src_endofpacket_o), .src_valid_o(src_valid_o),
    .src_empty_o(src_empty_o), .src_channel_o(src_channel_o),
    .src_ready_i(src_ready_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (arst_n && src_valid_o && src_ready_i) begin
      mon_w = {src_data_o, src_startofpacket_o, src_endofpacket_o, src_empty_o, src_channel_o};
      got_q.push_back(mon_w);
    end
    if (arst_n && err_o) err_seen++;
  end

  // Reference: packet split into groups of 4 beats, first beat in the top 32 bits, missing beats zero.
  task automatic model_packet(input logic [31:0] d[$], input logic [7:0] ch, input logic [1:0] lem);
    int n = d.size();
    int nw = (n + 3) / 4;
    out_t o;
    for (int w = 0; w < nw; w++) begin
      o.data = '0;
      for (int k = 0; k < 4; k++) begin
        o.data = o.data << 32;
        if (w * 4 + k < n) o.data = o.data | {96'b0, d[w*4+k]};
      end
      o.sop   = (w == 0);
      o.eop   = (w == nw - 1);
      o.empty = o.eop ? 4'((nw * 4 - n) * 4 + lem) : 4'd0;
      o.ch    = ch;
      exp_q.push_back(o);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic s, input logic e,
                           input logic [1:0] em, input logic [7:0] ch);
    bit acc = 0;
    snk_data_i = d; snk_startofpacket_i = s; snk_endofpacket_i = e;
    snk_empty_i = em; snk_channel_i = ch; snk_valid_i = 1'b1;
    for (int c = 0; c < 200 && !acc; c++) begin
      if (bp_en) src_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = snk_ready_o;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      tests++; fails++;
      $display("FAIL beat_accept_timeout got=0 exp=1");
    end
  endtask

  task automatic idle();
    snk_valid_i = 1'b0; snk_startofpacket_i = 1'b0; snk_endofpacket_i = 1'b0;
  endtask

  task automatic send_packet(input int n, input logic [7:0] ch, input logic [1:0] lem);
    logic [31:0] d[$];
    for (int i = 0; i < n; i++) d.push_back($urandom);
    model_packet(d, ch, lem);
    for (int i = 0; i < n; i++)
      send_beat(d[i], i == 0, i == n - 1, (i == n - 1) ? lem : 2'd0, ch);
  endtask

  task automatic wait_drain(input int maxc);
    for (int c = 0; c < maxc && got_q.size() < exp_q.size(); c++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 arst_n = 1'b0;
    #1;
    tests++; if (src_valid_o !== 1'b0 || src_data_o !== '0 || src_startofpacket_o !== 1'b0 ||
                 src_endofpacket_o !== 1'b0) begin
      fails++; $display("FAIL reset_src got=%b/%h exp=0/0", src_valid_o, src_data_o);
    end
    tests++; if (src_empty_o !== 4'd0 || src_channel_o !== 8'd0 || err_o !== 1'b0) begin
      fails++; $display("FAIL reset_side got=%h/%h/%b exp=0", src_empty_o, src_channel_o, err_o);
    end
    repeat (3) @(posedge clk);
    #1 arst_n = 1'b1;
    tests++; if (snk_ready_o !== 1'b0) begin
      fails++; $display("FAIL reset_ready_before_clk got=%b exp=0", snk_ready_o);
    end
    @(posedge clk); #1;
    tests++; if (snk_ready_o !== 1'b1) begin
      fails++; $display("FAIL reset_ready_after_clk got=%b exp=1", snk_ready_o);
    end
  endtask

  task automatic test_basic();
    int e0 = err_seen;
    got_q.delete(); exp_q.delete();
    send_packet(8, 8'd5, 2'd0);
    idle();
    wait_drain(100);
    tests++; if (got_q.size() != 2) begin
      fails++; $display("FAIL basic_count got=%0d exp=2", got_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      tests++; if (got_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL basic_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    if (got_q.size() == 2) begin
      tests++; if (got_q[0].sop !== 1'b1 || got_q[0].eop !== 1'b0 || got_q[1].sop !== 1'b0 ||
                   got_q[1].eop !== 1'b1 || got_q[1].empty !== 4'd0 || got_q[1].ch !== 8'd5) begin
        fails++; $display("FAIL basic_flags got=%b%b%b%b exp=1001", got_q[0].sop, got_q[0].eop,
                          got_q[1].sop, got_q[1].eop);
      end
    end
    tests++; if (err_seen != e0) begin
      fails++; $display("FAIL basic_err got=%0d exp=0", err_seen - e0);
    end
  endtask

  task automatic test_empty();
    got_q.delete(); exp_q.delete();
    send_packet(6, 8'd7, 2'd2);
    send_packet(1, 8'd2, 2'd3);
    idle();
    wait_drain(100);
    tests++; if (got_q.size() != 3) begin
      fails++; $display("FAIL empty_count got=%0d exp=3", got_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      tests++; if (got_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL empty_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    if (got_q.size() == 3) begin
      tests++; if (got_q[1].empty !== 4'd10 || got_q[1].eop !== 1'b1 || got_q[1].data[63:0] !== 64'd0) begin
        fails++; $display("FAIL empty_six_beat got=%0d/%b/%h exp=10/1/0", got_q[1].empty,
                          got_q[1].eop, got_q[1].data[63:0]);
      end
      tests++; if (got_q[2].empty !== 4'd15 || got_q[2].sop !== 1'b1 || got_q[2].eop !== 1'b1) begin
        fails++; $display("FAIL empty_single got=%0d/%b/%b exp=15/1/1", got_q[2].empty,
                          got_q[2].sop, got_q[2].eop);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d[$];
    logic [142:0] snap;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 8; i++) d.push_back($urandom);
    model_packet(d, 8'd9, 2'd1);
    src_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(d[i], i == 0, 1'b0, 2'd0, 8'd9);
    snk_data_i = d[4]; snk_startofpacket_i = 1'b0; snk_endofpacket_i = 1'b0; snk_valid_i = 1'b1;
    snap = {src_valid_o, src_data_o, src_startofpacket_o, src_endofpacket_o, src_empty_o, src_channel_o};
    tests++; if (src_valid_o !== 1'b1) begin
      fails++; $display("FAIL bp_pending got=%b exp=1", src_valid_o);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++; if (snk_ready_o !== 1'b0 || {src_valid_o, src_data_o, src_startofpacket_o,
          src_endofpacket_o, src_empty_o, src_channel_o} !== snap) begin
        fails++; $display("FAIL bp_hold_c%0d got=%b/%h exp=0/%h", c, snk_ready_o, src_data_o, snap[141:14]);
      end
    end
    @(posedge clk); #1;
    src_ready_i = 1'b1;
    for (int i = 4; i < 8; i++) send_beat(d[i], 1'b0, i == 7, (i == 7) ? 2'd1 : 2'd0, 8'd9);
    idle();
    wait_drain(100);
    tests++; if (got_q.size() != 2) begin
      fails++; $display("FAIL bp_count got=%0d exp=2", got_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      tests++; if (got_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL bp_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] b[$];
    int e0 = err_seen;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) b.push_back($urandom);
    model_packet(b, 8'd4, 2'd1);
    send_beat($urandom, 1'b1, 1'b0, 2'd0, 8'd3);
    send_beat($urandom, 1'b0, 1'b0, 2'd0, 8'd3);
    send_beat(b[0], 1'b1, 1'b0, 2'd0, 8'd4);
    tests++; if (err_o !== 1'b1) begin
      fails++; $display("FAIL err_sop_in_accum got=%b exp=1", err_o);
    end
    send_beat(b[1], 1'b0, 1'b0, 2'd0, 8'd4);
    tests++; if (err_o !== 1'b0) begin
      fails++; $display("FAIL err_pulse_width got=%b exp=0", err_o);
    end
    send_beat(b[2], 1'b0, 1'b0, 2'd0, 8'd9);
    tests++; if (err_o !== 1'b1) begin
      fails++; $display("FAIL err_channel got=%b exp=1", err_o);
    end
    send_beat(b[3], 1'b0, 1'b1, 2'd1, 8'd4);
    send_beat($urandom, 1'b0, 1'b0, 2'd0, 8'd4);
    send_beat($urandom, 1'b0, 1'b1, 2'd2, 8'd4);
    idle();
    wait_drain(100);
    tests++; if (err_seen - e0 != 4) begin
      fails++; $display("FAIL err_count got=%0d exp=4", err_seen - e0);
    end
    tests++; if (got_q.size() != 1) begin
      fails++; $display("FAIL err_words got=%0d exp=1", got_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      tests++; if (got_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL err_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    longint t0;
    int e0 = err_seen;
    got_q.delete(); exp_q.delete();
    src_ready_i = 1'b1;
    t0 = $time;
    for (int p = 0; p < 3; p++) send_packet(8, 8'($urandom), 2'($urandom_range(0, 3)));
    tests++; if ($time - t0 != 240) begin
      fails++; $display("FAIL b2b_cycles got=%0d exp=24", ($time - t0) / 10);
    end
    bp_en = 1;
    for (int p = 0; p < 20; p++) begin
      send_packet($urandom_range(1, 13), 8'($urandom), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) begin
        idle(); @(posedge clk); #1;
      end
    end
    idle();
    bp_en = 0;
    src_ready_i = 1'b1;
    wait_drain(500);
    tests++; if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      tests++; if (got_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL b2b_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    tests++; if (err_seen != e0) begin
      fails++; $display("FAIL b2b_err got=%0d exp=0", err_seen - e0);
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    got_q.delete(); exp_q.delete();
    src_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send_beat($urandom | 32'h1, i == 0, 1'b0, 2'd0, 8'd6);
    idle();
    tests++; if (src_valid_o !== 1'b1) begin
      fails++; $display("FAIL rst_mid_pending got=%b exp=1", src_valid_o);
    end
    arst_n = 1'b0;
    #1;
    tests++; if (src_valid_o !== 1'b0 || src_data_o !== '0 || src_startofpacket_o !== 1'b0 ||
                 src_channel_o !== 8'd0 || snk_ready_o !== 1'b0) begin
      fails++; $display("FAIL rst_mid_outputs got=%b/%h/%b exp=0/0/0", src_valid_o, src_data_o, snk_ready_o);
    end
    @(posedge clk); #1 arst_n = 1'b1;
    @(posedge clk); #1;
    src_ready_i = 1'b1;
    e0 = err_seen;
    send_beat($urandom, 1'b0, 1'b1, 2'd0, 8'd6);
    idle();
    @(posedge clk); #1;
    tests++; if (err_seen - e0 != 1) begin
      fails++; $display("FAIL rst_mid_idle_state got=%0d exp=1", err_seen - e0);
    end
    send_packet(8, 8'd11, 2'd3);
    idle();
    wait_drain(100);
    tests++; if (got_q.size() != 2) begin
      fails++; $display("FAIL rst_mid_count got=%0d exp=2", got_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      tests++; if (got_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL rst_mid_word%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_backpressure();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
